rf_alu_n_pipe: RTL and testbench



---
 rtl/rf_alu_n_pipe.sv | 103 ++++++++++
 tb/tb_rf_alu_n_pipe.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_alu_n_pipe.sv
// Configurable add/subtract/logic ALU with a LAT-deep valid/ready pipeline.
// Define RF_ALU_OVF_EN to add the pipelined signed-overflow output Ovf.
module rf_alu_n_pipe #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LAT   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic             Carry_in,
  input  logic             End_bar,
  input  logic             Cmpl_X,
  input  logic             Cmpl_Y,
  input  logic             Op_XOR,
  input  logic             Op_AND,
  input  logic             Op_ARITH,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] Z,
  output logic             Carry_out,
`ifdef RF_ALU_OVF_EN
  output logic             Ovf,
`endif
  output logic             out_valid,
  input  logic             out_ready
);

  logic [WIDTH-1:0] xc;
  logic [WIDTH-1:0] yc;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] g;
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] z_d;
  logic             advance;

  // Result is computed before the first stage; the stages only carry it.
  always_comb begin
    xc   = X ^ {WIDTH{Cmpl_X}};
    yc   = Y ^ {WIDTH{Cmpl_Y}};
    p    = xc ^ yc;
    g    = xc & yc;
    c    = '0;
    c[0] = Carry_in & End_bar;
    for (int i = 0; i < int'(WIDTH); i++) begin
      c[i+1] = End_bar & Op_ARITH & (g[i] | (p[i] & c[i]));
    end
    z_d  = ((p & {WIDTH{Op_XOR}}) | (g & {WIDTH{Op_AND}}))
         ^ (c[WIDTH-1:0] & {WIDTH{Op_ARITH}});
  end

  // Whole pipe moves in lockstep; an empty output slot never blocks.
  assign advance  = out_ready | ~out_valid;
  assign in_ready = advance;

  logic [LAT-1:0]   vld_q;
  logic [LAT-1:0]   co_q;
  logic [WIDTH-1:0] z_q [LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      co_q  <= '0;
      for (int k = 0; k < int'(LAT); k++) begin
        z_q[k] <= '0;
      end
    end else if (advance) begin
      vld_q[0] <= in_valid;
      co_q[0]  <= c[WIDTH];
      z_q[0]   <= z_d;
      for (int k = 1; k < int'(LAT); k++) begin
        vld_q[k] <= vld_q[k-1];
        co_q[k]  <= co_q[k-1];
        z_q[k]   <= z_q[k-1];
      end
    end
  end

  assign out_valid = vld_q[LAT-1];
  assign Carry_out = co_q[LAT-1];
  assign Z         = z_q[LAT-1];

`ifdef RF_ALU_OVF_EN
  logic             ovf_d;
  logic [LAT-1:0]   ov_q;

  assign ovf_d = Op_ARITH & End_bar & (c[WIDTH] ^ c[WIDTH-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ov_q <= '0;
    end else if (advance) begin
      ov_q[0] <= ovf_d;
      for (int k = 1; k < int'(LAT); k++) begin
        ov_q[k] <= ov_q[k-1];
      end
    end
  end

  assign Ovf = ov_q[LAT-1];
`endif

endmodule

// File: tb/tb_rf_alu_n_pipe.sv
// Scoreboard bench for rf_alu_n_pipe: directed vectors, backpressure, reset and bubbles.
module tb_rf_alu_n_pipe;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned LAT   = 3;

  // Control vector order: {Carry_in, End_bar, Cmpl_X, Cmpl_Y, Op_XOR, Op_AND, Op_ARITH}
  localparam logic [6:0] C_ADD   = 7'b0100101;
  localparam logic [6:0] C_SUB   = 7'b1101101;
  localparam logic [6:0] C_AND   = 7'b0100010;
  localparam logic [6:0] C_XOR   = 7'b0100100;
  localparam logic [6:0] C_KILL  = 7'b0000101;
  localparam logic [6:0] C_NONE  = 7'b1100000;
  localparam logic [6:0] C_CXXOR = 7'b0110100;
  localparam logic [6:0] C_CARRY = 7'b1100001;
  localparam logic [6:0] C_ALL   = 7'b0100111;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] X, Y;
  logic             Carry_in, End_bar, Cmpl_X, Cmpl_Y;
  logic             Op_XOR, Op_AND, Op_ARITH;
  logic             in_valid, in_ready;
  logic [WIDTH-1:0] Z;
  logic             Carry_out;
  logic             out_valid, out_ready;
`ifdef RF_ALU_OVF_EN
  logic             Ovf;
`endif

  rf_alu_n_pipe #(.WIDTH(WIDTH), .LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .X(X), .Y(Y),
    .Carry_in(Carry_in), .End_bar(End_bar), .Cmpl_X(Cmpl_X), .Cmpl_Y(Cmpl_Y),
    .Op_XOR(Op_XOR), .Op_AND(Op_AND), .Op_ARITH(Op_ARITH),
    .in_valid(in_valid), .in_ready(in_ready),
    .Z(Z), .Carry_out(Carry_out),
`ifdef RF_ALU_OVF_EN
    .Ovf(Ovf),
`endif
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] z;
    logic             co;
    logic             ov;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   n_push = 0;
  int   n_pop  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every output transfer pops and checks the oldest expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_output: got Z=0x%0h, expected no output", Z);
        end else begin
          mon_e = sb.pop_front();
          n_pop++;
          chk("result_z", 32'(Z), 32'(mon_e.z));
          chk("result_carry_out", 32'(Carry_out), 32'(mon_e.co));
`ifdef RF_ALU_OVF_EN
          chk("result_ovf", 32'(Ovf), 32'(mon_e.ov));
`endif
        end
      end
    end
  end

  // Present one operation, wait until accepted, record its expected result.
  task automatic issue(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                       input logic [6:0] ctl, input logic [WIDTH-1:0] ez,
                       input logic eco, input logic eov);
    int n;
    exp_t e;
    n = 0;
    X = x;
    Y = y;
    {Carry_in, End_bar, Cmpl_X, Cmpl_Y, Op_XOR, Op_AND, Op_ARITH} = ctl;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL accept_timeout: got in_ready=0, expected 1 within 200 cycles");
    end else begin
      e.z  = ez;
      e.co = eco;
      e.ov = eov;
      sb.push_back(e);
      n_push++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    in_valid = 1'b0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_empty", 32'(sb.size()), 32'd0);
    chk("drain_count", 32'(n_pop), 32'(n_push));
  endtask

  task automatic hold_after_first_valid();
    int n;
    logic [WIDTH-1:0] zc;
    logic             cc;
    n = 0;
    @(posedge clk);
    #1;
    while (!out_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("bp_first_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b0;
    zc = Z;
    cc = Carry_out;
    repeat (4) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_z_frozen", 32'(Z), 32'(zc));
      chk("bp_co_frozen", 32'(Carry_out), 32'(cc));
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    X         = '0;
    Y         = '0;
    {Carry_in, End_bar, Cmpl_X, Cmpl_Y, Op_XOR, Op_AND, Op_ARITH} = 7'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;

    #12;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_z", 32'(Z), 32'd0);
    chk("reset_carry_out", 32'(Carry_out), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
`ifdef RF_ALU_OVF_EN
    chk("reset_ovf", 32'(Ovf), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Add with latency probe on an empty pipe
    issue(8'h0F, 8'h01, C_ADD, 8'h10, 1'b0, 1'b0);
    in_valid = 1'b0;
    chk("latency_edge0", 32'(out_valid), 32'd0);
    for (int k = 1; k < int'(LAT); k++) begin
      @(posedge clk);
      #1;
      chk("latency_edge", 32'(out_valid), 32'(k == int'(LAT) - 1));
    end
    drain();

    // Back-to-back directed vectors
    issue(8'h05, 8'h07, C_SUB,   8'hFE, 1'b0, 1'b0);
    issue(8'hFF, 8'h01, C_ADD,   8'h00, 1'b1, 1'b0);
    issue(8'h7F, 8'h01, C_ADD,   8'h80, 1'b0, 1'b1);
    issue(8'hC3, 8'hA5, C_AND,   8'h81, 1'b0, 1'b0);
    issue(8'hC3, 8'hA5, C_XOR,   8'h66, 1'b0, 1'b0);
    issue(8'h0F, 8'h01, C_KILL,  8'h0E, 1'b0, 1'b0);
    issue(8'hAA, 8'h55, C_NONE,  8'h00, 1'b0, 1'b0);
    issue(8'h00, 8'h00, C_CXXOR, 8'hFF, 1'b0, 1'b0);
    issue(8'h01, 8'h01, C_CARRY, 8'h03, 1'b0, 1'b0);
    issue(8'h03, 8'h01, C_ALL,   8'h05, 1'b0, 1'b0);
    issue(8'h80, 8'h80, C_ADD,   8'h00, 1'b1, 1'b1);
    drain();

    // Backpressure: five-operation stream with a 4-cycle output stall
    fork
      begin
        issue(8'h01, 8'h01, C_ADD, 8'h02, 1'b0, 1'b0);
        issue(8'h02, 8'h02, C_ADD, 8'h04, 1'b0, 1'b0);
        issue(8'h03, 8'h03, C_ADD, 8'h06, 1'b0, 1'b0);
        issue(8'h04, 8'h04, C_ADD, 8'h08, 1'b0, 1'b0);
        issue(8'h05, 8'h05, C_ADD, 8'h0A, 1'b0, 1'b0);
        in_valid = 1'b0;
      end
      hold_after_first_valid();
    join
    drain();

    // Reset with three operations in flight
    issue(8'hFF, 8'h01, C_ADD, 8'h00, 1'b1, 1'b0);
    issue(8'h0F, 8'h01, C_ADD, 8'h10, 1'b0, 1'b0);
    issue(8'hC3, 8'hA5, C_AND, 8'h81, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset_out_valid", 32'(out_valid), 32'd0);
    chk("midreset_z", 32'(Z), 32'd0);
    chk("midreset_carry_out", 32'(Carry_out), 32'd0);
    sb.delete();
    n_push = n_pop;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (LAT + 3) begin
      @(negedge clk);
      chk("postreset_no_stale", 32'(out_valid), 32'd0);
    end
    @(posedge clk);
    #1;

    // Bubble pattern 1,0,1
    issue(8'h10, 8'h20, C_ADD, 8'h30, 1'b0, 1'b0);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    issue(8'hF0, 8'h0F, C_XOR, 8'hFF, 1'b0, 1'b0);
    in_valid = 1'b0;
    chk("bubble_slot0", 32'(out_valid), 32'd1);
    @(posedge clk);
    #1;
    chk("bubble_slot1", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    chk("bubble_slot2", 32'(out_valid), 32'd1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: got no completion, expected finish before 200000 time units");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
